// File: rtl/single_pkg.sv
// single_pkg: IEEE-754 single field widths, special constants and accumulator FSM states.
package single_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
  } fp32_t;
  typedef enum logic {ACC, HOLD} acc_state_e;
endpackage

// File: rtl/single_add_pos.sv
// single_add_pos: combinational positive-only single adder, truncating, saturating to +Inf.
module single_add_pos
  import single_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        ovf
);
  fp32_t x, y, big, sml;
  logic [EXP_W-1:0] diff;
  logic [MAN_W:0] mb, ms;
  logic [MAN_W+1:0] s;
  logic [EXP_W:0] e;
  always_comb begin
    x = a;
    y = b;
    big = (x.exp >= y.exp) ? x : y;
    sml = (x.exp >= y.exp) ? y : x;
    diff = big.exp - sml.exp;
    mb = {1'b1, big.mant};
    ms = (sml.exp == '0 || diff > 8'd24) ? '0 : {1'b1, sml.mant} >> diff;
    s = {1'b0, mb} + {1'b0, ms};
    e = {1'b0, big.exp} + {8'd0, s[MAN_W+1]};
    ovf = big.exp == 8'hFF || e == 9'd255;
    sum = (big.exp == '0) ? '0 : ovf ? POS_INF : {1'b0, e[EXP_W-1:0], s[MAN_W+1] ? s[MAN_W:1] : s[MAN_W-1:0]};
  end
endmodule

// File: rtl/single_exp_accum.sv
// single_exp_accum: sums a framed stream of exp outputs into a held single-precision total.
module single_exp_accum
  import single_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_nan
);
  acc_state_e state_q, state_d;
  logic [31:0] acc_q, acc_d, sum_q, sum_d, op, add_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d, count_q, count_d, cnt_inc;
  logic ovf_q, ovf_d, nan_q, nan_d, oovf_q, oovf_d, onan_q, onan_d;
  logic xfer, op_nan, add_ovf;
  fp32_t din;
  single_add_pos u_add (.a(acc_q), .b(op), .sum(add_sum), .ovf(add_ovf));
  always_comb begin
    din = in_data;
    op_nan = din.exp == 8'hFF && din.mant != '0;
    // Sign dropped, denormals flushed; NaN contributes nothing since the result is forced to QNAN.
    op = (din.exp == '0 || op_nan) ? '0 : {1'b0, in_data[30:0]};
    in_ready = state_q == ACC;
    out_valid = state_q == HOLD;
    xfer = in_valid && in_ready;
    cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    nan_d = nan_q;
    sum_d = sum_q;
    count_d = count_q;
    oovf_d = oovf_q;
    onan_d = onan_q;
    if (xfer) begin
      acc_d = add_sum;
      cnt_d = cnt_inc;
      ovf_d = ovf_q | add_ovf;
      nan_d = nan_q | op_nan;
      if (in_last) begin
        state_d = HOLD;
        sum_d = (nan_q | op_nan) ? QNAN : add_sum;
        count_d = cnt_inc;
        oovf_d = ovf_q | add_ovf;
        onan_d = nan_q | op_nan;
      end
    end else if (state_q == HOLD && out_ready) begin
      state_d = ACC;
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      nan_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      nan_q <= 1'b0;
      sum_q <= '0;
      count_q <= '0;
      oovf_q <= 1'b0;
      onan_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      nan_q <= nan_d;
      sum_q <= sum_d;
      count_q <= count_d;
      oovf_q <= oovf_d;
      onan_q <= onan_d;
    end
  end
  assign out_sum = sum_q;
  assign out_count = count_q;
  assign out_ovf = oovf_q;
  assign out_nan = onan_q;
endmodule

// File: doc/single_exp_accum.md
Name: single_exp_accum

Overview:
- Downstream consumer of the single-precision exp stage.
- Sums a framed stream of non-negative IEEE-754 single values (exp outputs) into one single-precision total, i.e. the softmax denominator.
- Accepts one operand per clock via a valid/ready handshake.
- Presents the frame sum and element count on a held output handshake for the normalising divider.

Parameters:
- CNT_W, 16: width of the per-frame element counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  32  IEEE-754 single operand (exp result).
- in_last  in  1  operand is final element of the frame.
- out_valid  out  1  frame result held.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  32  IEEE-754 single frame sum.
- out_count  out  CNT_W  number of elements accepted in the frame.
- out_ovf  out  1  sum saturated to +Inf during the frame.
- out_nan  out  1  a NaN operand was seen in the frame.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=ACC, accumulator=0x00000000, count=0, sticky flags=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, out_nan=0, in_ready=1 from the following cycle.
  - Reset mid-frame discards the partial sum.
  - Reset while in HOLD drops the pending result.
- FSM states:
  - ACC: in_ready=1. Transfer = in_valid && in_ready. A transfer adds the operand into the accumulator and increments count; count saturates at all-ones.
  - ACC -> HOLD: a transfer with in_last=1. At that edge, out_sum gets the accumulator plus the operand, out_count gets the final count, and the flags are latched. out_valid=1 on the next cycle, giving 1-cycle latency from the last transfer.
  - HOLD: in_ready=0, outputs stable.
  - HOLD -> ACC: out_ready=1 at an edge. That edge clears out_valid, the accumulator, count and the flags. The next frame may start on the following cycle.
  - in_valid=0 in ACC: no change.
- Operand preprocessing:
  - Exponent field 0 (zero or denormal): flushed to +0. Still counted.
  - Sign bit set: magnitude used (exp never produces negatives). No flag.
  - NaN (exp=255, mant!=0): out_nan sticky. Final out_sum=0x7FC00000 regardless of other operands.
  - +Inf operand: accumulator becomes 0x7F800000 and out_ovf is set.
- Addition (single combinational path, accumulator register fed back, positive operands only):
  - Mantissas are 24 bits with the hidden 1.
  - Align the smaller operand by right shift of the exponent difference. A shift of 25 or more contributes 0.
  - 25-bit sum. On carry, shift right 1 and increment the exponent.
  - Rounding is truncation (round toward zero). Discarded bits are lost and there are no guard/sticky bits.
  - Result exponent 255: result=0x7F800000, out_ovf sticky.
  - Once the accumulator is Inf it stays Inf for the frame.
  - 0 + x = x exactly.
- Simultaneous events:
  - rst has priority over all handshakes.
  - in_valid during HOLD is ignored, because in_ready=0; the source must hold its data.

Decomposition:
- Shared package single_pkg:
  - Field-width constants: EXP_W=8, MAN_W=23, BIAS=127.
  - Constants: POS_INF=32'h7F800000, QNAN=32'h7FC00000.
  - A packed struct typedef for sign/exp/mant.
- One sub-module: single_add_pos, the combinational positive-only truncating adder (32b a, 32b b -> 32b sum, ovf). It is reused later by the softmax stage.

Test Plan:
- Frame {1.0=0x3F800000, 2.0=0x40000000, 0.5=0x3F000000 last} -> out_sum=0x40600000 (3.5), out_count=3, ovf=0, nan=0, out_valid 1 cycle after last.
- Single-element frame 0x40490FDB with last -> out_sum=0x40490FDB, out_count=1.
- Truncation: {0x3F800000, 0x33800000 (2^-24) last} -> 0x3F800000. Denormal 0x00000001 + 1.0 -> 0x3F800000, count=2.
- Overflow: {0x7F7FFFFF, 0x7F7FFFFF last} -> out_sum=0x7F800000, out_ovf=1. NaN frame {1.0, 0x7FC00001 last} -> 0x7FC00000, out_nan=1.
- Backpressure: hold out_ready=0 for 5 cycles after a result while driving in_valid -> in_ready=0, outputs stable. Then assert out_ready -> next frame {2.0 last} gives 0x40000000, proving the accumulator was cleared.
- Reset mid-frame: after {1.0, 1.0}, pulse rst -> out_valid=0; then frame {0.25 last} gives 0x3E800000, count=1.
